// File: rtl/fm_preemphasis.sv
// fm_preemphasis: 75 us broadcast-FM pre-emphasis, y = (x - A*x[n-1]) >>> SHIFT
// A*x[n-1] is formed by a 16-step bit-serial shift-add multiplier.
//
// Ports:
//   clk       single clock (clk_216)
//   rst_n     asynchronous active-low reset
//   data_in   signed sample x[n], qualified by stb_in
//   stb_in    one-cycle input sample strobe
//   data_out  signed y[n], held between output strobes
//   stb_out   one-cycle output strobe, data_out valid while high
//   busy      high while a sample is in flight
//   overrun   one-cycle pulse for each strobe dropped while busy
//
// Build option: define FM_PREEMPH_SAT_EN to saturate the result to WIDTH
// bits; otherwise the result wraps modulo 2^WIDTH.
module fm_preemphasis #(
    parameter int WIDTH = 16,
    parameter int COEF  = 24822,
    parameter int SHIFT = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] data_in,
    input  logic                    stb_in,
    output logic signed [WIDTH-1:0] data_out,
    output logic                    stb_out,
    output logic                    busy,
    output logic                    overrun
);

    localparam int AW = WIDTH + 16;
    localparam int DW = WIDTH + 2;
    localparam logic [15:0] W_COEF = 16'(COEF);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_OUT
    } state_t;

    state_t                  r_state;
    logic signed [WIDTH-1:0] r_x;
    logic signed [WIDTH-1:0] r_xprev;
    logic signed [AW-1:0]    r_acc;
    logic        [3:0]       r_cnt;
    logic signed [WIDTH-1:0] r_data;
    logic                    r_stb;
    logic                    r_busy;
    logic                    r_ovr;

    state_t                  w_state_nxt;
    logic signed [WIDTH-1:0] w_x_nxt;
    logic signed [WIDTH-1:0] w_xprev_nxt;
    logic signed [AW-1:0]    w_acc_nxt;
    logic        [3:0]       w_cnt_nxt;
    logic signed [WIDTH-1:0] w_data_nxt;
    logic                    w_stb_nxt;
    logic                    w_busy_nxt;
    logic                    w_ovr_nxt;

    logic                    w_coef_bit;
    logic signed [AW-1:0]    w_xp_ext;
    logic signed [AW-1:0]    w_addend;
    logic signed [WIDTH:0]   w_prod_q;
    logic signed [DW-1:0]    w_d;
    logic signed [WIDTH-1:0] w_fit;

    assign w_coef_bit = W_COEF[r_cnt];
    assign w_xp_ext   = {{16{r_xprev[WIDTH-1]}}, r_xprev};
    assign w_addend   = w_xp_ext << r_cnt;

    // Upper bits of acc are exactly acc >>> 15 (floor toward -inf).
    assign w_prod_q = r_acc[AW-1:15];
    assign w_d      = {{2{r_x[WIDTH-1]}}, r_x} - {w_prod_q[WIDTH], w_prod_q};

`ifdef FM_PREEMPH_SAT_EN
    localparam logic signed [DW-1:0] MAXV = DW'((1 <<< (WIDTH - 1)) - 1);
    localparam logic signed [DW-1:0] MINV = ~MAXV;

    logic signed [DW-1:0] w_r;

    assign w_r = w_d >>> SHIFT;

    always_comb begin
        w_fit = w_r[WIDTH-1:0];
        if (w_r > MAXV) begin
            w_fit = MAXV[WIDTH-1:0];
        end else if (w_r < MINV) begin
            w_fit = MINV[WIDTH-1:0];
        end
    end
`else
    assign w_fit = WIDTH'(w_d >>> SHIFT);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_xprev_nxt = r_xprev;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data;
        w_stb_nxt   = 1'b0;
        w_ovr_nxt   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (stb_in) begin
                    w_x_nxt     = data_in;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_MUL;
                end
            end
            S_MUL: begin
                w_ovr_nxt = stb_in;
                if (w_coef_bit) begin
                    w_acc_nxt = r_acc + w_addend;
                end
                w_cnt_nxt = r_cnt + 4'd1;
                if (r_cnt == 4'd15) begin
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                w_ovr_nxt   = stb_in;
                w_data_nxt  = w_fit;
                w_stb_nxt   = 1'b1;
                w_xprev_nxt = r_x;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_xprev <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_stb   <= 1'b0;
            r_busy  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_xprev <= w_xprev_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
            r_stb   <= w_stb_nxt;
            r_busy  <= w_busy_nxt;
            r_ovr   <= w_ovr_nxt;
        end
    end

    assign data_out = r_data;
    assign stb_out  = r_stb;
    assign busy     = r_busy;
    assign overrun  = r_ovr;

endmodule

// File: tb/tb_fm_preemphasis.sv
// tb_fm_preemphasis: scoreboard bench for fm_preemphasis
// Default instance plus a SHIFT=0 instance for the fit() corner.
module tb_fm_preemphasis;

    localparam int COEF = 24822;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] data_in = '0;
    logic               stb_in = 1'b0;
    logic signed [15:0] data_out;
    logic               stb_out;
    logic               busy;
    logic               overrun;

    logic signed [15:0] z_data_in = '0;
    logic               z_stb_in = 1'b0;
    logic signed [15:0] z_data_out;
    logic               z_stb_out;
    logic               z_busy;
    logic               z_overrun;

    int total = 0;
    int bad = 0;
    int xp_m = 0;
    int sb[$];

    always #5 clk = ~clk;

    fm_preemphasis u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .stb_in   (stb_in),
        .data_out (data_out),
        .stb_out  (stb_out),
        .busy     (busy),
        .overrun  (overrun)
    );

    fm_preemphasis #(
        .WIDTH (16),
        .COEF  (COEF),
        .SHIFT (0)
    ) u_s0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (z_data_in),
        .stb_in   (z_stb_in),
        .data_out (z_data_out),
        .stb_out  (z_stb_out),
        .busy     (z_busy),
        .overrun  (z_overrun)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model(input int x, input int xp, input int sh);
        longint p;
        longint d;
        longint r;
        logic [63:0] rv;
        p = longint'(xp) * COEF;
        d = longint'(x) - (p >>> 15);
        r = d >>> sh;
`ifdef FM_PREEMPH_SAT_EN
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
`else
        rv = r;
        return int'($signed(rv[15:0]));
`endif
    endfunction

    always @(negedge clk) begin
        if (stb_out) begin
            if (sb.size() == 0) begin
                check("spurious_stb", sb.size(), 1);
            end else begin
                check("data", int'(data_out), sb.pop_front());
            end
        end
    end

    task automatic seq(input logic signed [15:0] x, input int drop_k,
                       input int rst_k, input int len);
        int first;
        int nb;
        int ns;
        int nov;
        int ovk;
        first = 0;
        nb = 0;
        ns = 0;
        nov = 0;
        ovk = 0;
        if (rst_k == 0) begin
            sb.push_back(model(int'(x), xp_m, 1));
            xp_m = int'(x);
        end
        data_in = x;
        stb_in = 1'b1;
        for (int k = 1; k <= len; k++) begin
            @(posedge clk);
            #1;
            stb_in = (k == drop_k);
            data_in = (k == drop_k) ? 16'sh5a5a : x;
            if (rst_k > 0 && k == rst_k) begin
                rst_n = 1'b0;
                xp_m = 0;
            end
            if (rst_k > 0 && k == rst_k + 3) rst_n = 1'b1;
            @(negedge clk);
            if (rst_k > 0 && k == rst_k) begin
                check("rst_data", int'(data_out), 0);
                check("rst_stb", int'(stb_out), 0);
                check("rst_busy", int'(busy), 0);
                check("rst_ovr", int'(overrun), 0);
            end
            if (busy) nb++;
            if (stb_out) begin
                ns++;
                if (first == 0) first = k;
            end
            if (overrun) begin
                nov++;
                ovk = k;
            end
        end
        if (rst_k == 0) begin
            check("latency", first, 18);
            check("busy_cycles", nb, 17);
            check("stb_count", ns, 1);
        end else begin
            check("rst_no_stb", ns, 0);
        end
        check("ovr_count", nov, (drop_k > 0) ? 1 : 0);
        if (drop_k > 0) check("ovr_cycle", ovk, drop_k + 1);
    endtask

    initial begin
        int found;
        logic signed [15:0] v;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", int'(data_out), 0);
        check("reset_stb", int'(stb_out), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_ovr", int'(overrun), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        seq(16'sd1000, 0, 0, 24);
        check("plan_500", int'(data_out), 500);
        seq(16'sd1000, 0, 0, 24);
        check("plan_121", int'(data_out), 121);
        seq(-16'sd1000, 0, 0, 24);
        check("plan_m879", int'(data_out), -879);

        seq(16'sd2000, 5, 0, 24);
        seq(-16'sd3000, 0, 8, 24);
        seq(16'sd1000, 0, 0, 24);
        check("post_rst_500", int'(data_out), 500);

        seq(16'sd300, 0, 0, 18);
        seq(-16'sd200, 0, 0, 24);

        seq(16'sd32767, 0, 0, 24);
        seq(-16'sd32768, 0, 0, 24);
        repeat (8) begin
            v = 16'($urandom);
            seq(v, 0, 0, 24);
        end

        @(posedge clk);
        #1;
        z_data_in = -16'sd32768;
        z_stb_in = 1'b1;
        @(posedge clk);
        #1;
        z_stb_in = 1'b0;
        found = 0;
        for (int k = 0; k < 30 && found == 0; k++) begin
            @(negedge clk);
            if (z_stb_out) found = 1;
        end
        check("s0_first_seen", found, 1);
        check("s0_first", int'(z_data_out), model(-32768, 0, 0));
        @(posedge clk);
        #1;
        z_data_in = 16'sd32767;
        z_stb_in = 1'b1;
        @(posedge clk);
        #1;
        z_stb_in = 1'b0;
        found = 0;
        for (int k = 0; k < 30 && found == 0; k++) begin
            @(negedge clk);
            if (z_stb_out) found = 1;
        end
        check("s0_fit_seen", found, 1);
`ifdef FM_PREEMPH_SAT_EN
        check("s0_fit", int'(z_data_out), 32767);
`else
        check("s0_fit", int'(z_data_out), -7947);
`endif

        repeat (4) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fm_preemphasis.md
# fm_preemphasis

Broadcast-FM 75 µs pre-emphasis filter placed directly upstream of the transmitter's `data_in`/`stb_in` port, in the `clk_216` domain. It accepts one signed audio sample per input strobe, at 48 kHz, from the strobe-aligned microphone path. It computes y[n] = (x[n] − A·x[n−1]) >>> SHIFT using a bit-serial shift-add multiplier. It then emits the result with a single-cycle output strobe that feeds the transmitter's input directly.

## Interface
- `WIDTH`, 16: sample width, two's complement, in and out.
- `COEF`, 24822: magnitude of A in Q0.15, unsigned, range 0..32767. 24822 ≈ exp(−1/(75 µs·48 kHz))·2^15.
- `SHIFT`, 1: arithmetic right shift applied to the difference, range 0..2.
- `clk`  in  1  single clock (`clk_216`).
- `rst_n`  in  1  reset; asynchronous, active-low.
- `data_in`  in  WIDTH  signed sample x[n]; valid only while `stb_in` is high.
- `stb_in`  in  1  one-cycle sample strobe.
- `data_out`  out  WIDTH  signed y[n]; holds its value between strobes.
- `stb_out`  out  1  one-cycle strobe; `data_out` is valid while it is high.
- `busy`  out  1  high while a sample is in flight.
- `overrun`  out  1  one-cycle pulse for each strobe dropped while busy.

## Operation
- Internal state: sample register `x`, history register `xprev` (x[n−1]), accumulator `acc` (signed, WIDTH+16 bits), bit counter `cnt` (0..15).
- FSM states: IDLE, MUL, OUT.
- IDLE, `stb_in`=1:
  - x ← `data_in`, acc ← 0, cnt ← 0, go to MUL.
- MUL: one step per cycle for 16 cycles, LSB first:
  - If COEF[cnt] = 1, acc ← acc + (sign-extended `xprev` << cnt).
  - cnt increments each step.
  - After the step with cnt = 15, go to OUT.
- OUT:
  - d = sext(x) − (acc >>> 15), at WIDTH+2 bits. The `>>>` is an arithmetic shift, so it floors toward −∞.
  - r = d >>> SHIFT, also floored.
  - `data_out` ← fit(r), where fit is defined under Configuration.
  - `stb_out` ← 1, `xprev` ← x, go to IDLE.
- `xprev` always holds the last accepted input, not the last output.
- `busy` = 1 in MUL and OUT, 0 in IDLE.
- `stb_in` while `busy` = 1: the sample is discarded, no state changes, and `overrun` pulses for one cycle.
- `stb_in` in the same cycle as `stb_out`: the FSM is already in IDLE, so the sample is accepted normally.

## Timing
- Reset values: `data_out`=0, `stb_out`=0, `busy`=0, `overrun`=0, `xprev`=0, `x`=0, `acc`=0, `cnt`=0, state IDLE.
- Reset takes effect immediately. An assertion mid-operation abandons the sample: no `stb_out` is produced for it, and the next accepted sample sees `xprev`=0.
- Latency: `stb_in` high in cycle n gives `stb_out` high in cycle n+18 only (WIDTH+2 for WIDTH=16).
- `busy` is high in cycles n+1..n+17.
- Minimum input strobe spacing is 18 cycles. At 48 kHz on 216 MHz the spacing is 4500 cycles.
- `overrun` is high in the cycle after the dropped `stb_in`.
- All outputs are registered.

## Configuration
- `FM_PREEMPH_SAT_EN` defined: fit(r) clamps to the range [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- `FM_PREEMPH_SAT_EN` undefined: fit(r) = r[WIDTH−1:0], which wraps modulo 2^WIDTH.
- With SHIFT ≥ 1 and COEF ≤ 32767 the two builds are bit-identical. They differ only when SHIFT = 0.

## Test plan
- Defaults, reset, then `stb_in` with x=1000 in cycle n -> `stb_out` only in cycle n+18, `data_out`=500, `busy` high in n+1..n+17.
- Next sample x=1000 -> A·1000 floors to 757, so `data_out`=(1000−757)>>>1=121.
- Next sample x=−1000 with `xprev`=1000 -> d = −1757, `data_out`=−879 (floored, not −878).
- SHIFT=0 instance, `xprev`=−32768, x=32767 -> d = 57589. Expect `data_out`=32767 with `FM_PREEMPH_SAT_EN` defined, and −7947 without it.
- `stb_in` in cycles n and n+5 -> `overrun` pulses in n+6, exactly one `stb_out` in n+18, carrying the cycle-n sample's result.
- `rst_n` low in cycle n+8 of an in-flight sample -> all outputs 0, no `stb_out`. After release, x=1000 gives `data_out`=500.
